// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache requests, absorbs misses,
// redirects and decode stalls, and drives the fetch/decode stage register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_fetch,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ready,
    input  logic [31:0] ic_data,
    output logic [31:0] instruction,
    output logic [31:0] PCNEXT,
    output logic        fetch_valid,
    output logic        block_pipe_instr_cache,
    output logic [1:0]  state_dbg
);

    // Icache handshake: a request is accepted in any cycle where ic_req and
    // ic_ready are both high; while ic_req=1 and ic_ready=0 the address holds.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_MISS  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pending_pc, pending_n;
    logic [31:0] skid, skid_n;
    logic [31:0] instr_n, pcnext_n;
    logic        valid_n;

    logic        do_deliver, do_bubble;
    logic [31:0] deliver_word;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign pc_plus4               = pc + 32'd4;
    assign redirect_target        = redirect_pc & ~32'h0000_0003;
    assign ic_addr                = pc;
    assign block_pipe_instr_cache = ic_req & ~ic_ready;
    assign state_dbg              = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pending_pc  <= 32'd0;
            skid        <= 32'd0;
            instruction <= NOP_INSTR;
            PCNEXT      <= 32'd0;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pending_pc  <= pending_n;
            skid        <= skid_n;
            instruction <= instr_n;
            PCNEXT      <= pcnext_n;
            fetch_valid <= valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pending_n    = pending_pc;
        skid_n       = skid;
        ic_req       = 1'b0;
        do_deliver   = 1'b0;
        do_bubble    = 1'b0;
        deliver_word = ic_data;

        case (state)
            S_FETCH: begin
                ic_req = en_fetch & ~redirect;
                if (redirect) begin
                    pc_n      = redirect_target;
                    do_bubble = 1'b1;
                end else if (en_fetch) begin
                    if (ic_ready) begin
                        do_deliver = 1'b1;
                    end else begin
                        do_bubble = 1'b1;
                        state_n   = S_MISS;
                    end
                end
            end
            S_MISS: begin
                ic_req = 1'b1;
                if (redirect) begin
                    pending_n = redirect_target;
                    do_bubble = 1'b1;
                    state_n   = S_DRAIN;
                end else if (ic_ready) begin
                    if (en_fetch) begin
                        do_deliver = 1'b1;
                        state_n    = S_FETCH;
                    end else begin
                        skid_n  = ic_data;
                        state_n = S_HOLD;
                    end
                end else if (en_fetch) begin
                    do_bubble = 1'b1;
                end
            end
            S_DRAIN: begin
                // The stale response must still be consumed before the new PC issues.
                ic_req    = 1'b1;
                do_bubble = 1'b1;
                if (redirect) begin
                    pending_n = redirect_target;
                end
                if (ic_ready) begin
                    pc_n    = redirect ? redirect_target : pending_pc;
                    state_n = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_n      = redirect_target;
                    do_bubble = 1'b1;
                    state_n   = S_FETCH;
                end else if (en_fetch) begin
                    deliver_word = skid;
                    do_deliver   = 1'b1;
                    state_n      = S_FETCH;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase

        if (reset) begin
            ic_req = 1'b0;
        end

        instr_n  = instruction;
        pcnext_n = PCNEXT;
        valid_n  = fetch_valid;
        if (do_deliver) begin
            instr_n  = deliver_word;
            pcnext_n = pc_plus4;
            valid_n  = 1'b1;
            pc_n     = pc_plus4;
        end else if (do_bubble) begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-during-miss sequence,
// then random traffic checked against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] K        = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_fetch, redirect, ic_ready;
    logic [31:0] redirect_pc, ic_data;
    logic        ic_req, fetch_valid, block_pipe_instr_cache;
    logic [31:0] ic_addr, instruction, PCNEXT;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .en_fetch(en_fetch), .redirect(redirect),
        .redirect_pc(redirect_pc), .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_ready(ic_ready), .ic_data(ic_data), .instruction(instruction),
        .PCNEXT(PCNEXT), .fetch_valid(fetch_valid),
        .block_pipe_instr_cache(block_pipe_instr_cache), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_blk;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcn;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic en, input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr, input logic e_blk,
                       input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pcn);
        vec_t v;
        v.en = en; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_blk = e_blk;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pcn = e_pcn;
        vq.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_instr, m_pcn, m_target;
    logic        m_valid, m_busy, m_discard;
    logic [31:0] exp_q[$];

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = NOP; m_pcn = 32'd0; m_valid = 1'b0;
        m_busy = 1'b0; m_discard = 1'b0; m_target = 32'd0;
        exp_q.delete();
    endtask

    function automatic logic model_req(input logic en, input logic rd);
        return m_busy | (exp_q.size() == 0 && en && !rd);
    endfunction

    task automatic model_deliver();
        m_instr = exp_q.pop_front();
        m_pcn   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic model_bubble();
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic [31:0] data);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (m_busy && m_discard) begin
            model_bubble();
            if (rd) m_target = tgt;
            if (rdy) begin
                m_busy = 1'b0; m_discard = 1'b0; m_pc = m_target;
            end
        end else if (m_busy) begin
            if (rd) begin
                m_discard = 1'b1; m_target = tgt; model_bubble();
            end else if (rdy) begin
                m_busy = 1'b0;
                exp_q.push_back(data);
                if (en) model_deliver();
            end else if (en) begin
                model_bubble();
            end
        end else if (exp_q.size() > 0) begin
            if (rd) begin
                exp_q.delete(); m_pc = tgt; model_bubble();
            end else if (en) begin
                model_deliver();
            end
        end else begin
            if (rd) begin
                m_pc = tgt; model_bubble();
            end else if (en) begin
                if (rdy) begin
                    exp_q.push_back(data); model_deliver();
                end else begin
                    m_busy = 1'b1; model_bubble();
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en_fetch = 1'b0; redirect = 1'b0; ic_ready = 1'b0;
        redirect_pc = 32'd0; ic_data = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; en_fetch = 1'b0; redirect = 1'b0; ic_ready = 1'b0;
        redirect_pc = 32'd0; ic_data = 32'd0;
        #12;
        check("rst_req", {31'd0, ic_req}, 32'd0);
        check("rst_addr", ic_addr, RESET_PC);
        check("rst_instr", instruction, NOP);
        check("rst_pcnext", PCNEXT, 32'd0);
        check("rst_valid", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // streaming hits, 3-cycle miss, redirect during miss, stall in miss, wrap
        add(1,0,0,1,  1,32'h1000,0, 1,K^32'h1000,32'h1004);
        add(1,0,0,1,  1,32'h1004,0, 1,K^32'h1004,32'h1008);
        add(1,0,0,0,  1,32'h1008,1, 0,NOP,32'h1008);
        add(1,0,0,0,  1,32'h1008,1, 0,NOP,32'h1008);
        add(1,0,0,0,  1,32'h1008,1, 0,NOP,32'h1008);
        add(1,0,0,1,  1,32'h1008,0, 1,K^32'h1008,32'h100C);
        add(1,0,0,1,  1,32'h100C,0, 1,K^32'h100C,32'h1010);
        add(1,0,0,0,  1,32'h1010,1, 0,NOP,32'h1010);
        add(1,1,32'h2003,0, 1,32'h1010,1, 0,NOP,32'h1010);
        add(1,0,0,0,  1,32'h1010,1, 0,NOP,32'h1010);
        add(1,0,0,1,  1,32'h1010,0, 0,NOP,32'h1010);
        add(1,0,0,1,  1,32'h2000,0, 1,K^32'h2000,32'h2004);
        add(1,0,0,0,  1,32'h2004,1, 0,NOP,32'h2004);
        add(0,0,0,1,  1,32'h2004,0, 0,NOP,32'h2004);
        add(0,0,0,0,  0,32'h2004,0, 0,NOP,32'h2004);
        add(1,0,0,0,  0,32'h2004,0, 1,K^32'h2004,32'h2008);
        add(1,0,0,1,  1,32'h2008,0, 1,K^32'h2008,32'h200C);
        add(1,1,32'hFFFF_FFFC,1, 0,32'h200C,0, 0,NOP,32'h200C);
        add(1,0,0,1,  1,32'hFFFF_FFFC,0, 1,K^32'hFFFF_FFFC,32'h0000_0000);
        add(1,0,0,1,  1,32'h0000_0000,0, 1,K,32'h0000_0004);
        add(0,0,0,1,  0,32'h0000_0004,0, 1,K,32'h0000_0004);
        add(1,0,0,0,  1,32'h0000_0004,1, 0,NOP,32'h0000_0004);
        add(1,1,32'h3000,0, 1,32'h0000_0004,1, 0,NOP,32'h0000_0004);
        add(0,1,32'h4001,0, 1,32'h0000_0004,1, 0,NOP,32'h0000_0004);
        add(1,0,0,1,  1,32'h0000_0004,0, 0,NOP,32'h0000_0004);
        add(1,0,0,1,  1,32'h4000,0, 1,K^32'h4000,32'h4004);
        add(1,0,0,0,  1,32'h4004,1, 0,NOP,32'h4004);
        add(0,0,0,1,  1,32'h4004,0, 0,NOP,32'h4004);
        add(0,1,32'h5000,0, 0,32'h4004,0, 0,NOP,32'h4004);
        add(1,0,0,1,  1,32'h5000,0, 1,K^32'h5000,32'h5004);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            en_fetch = vq[i].en; redirect = vq[i].rd; redirect_pc = vq[i].rpc;
            ic_ready = vq[i].rdy; ic_data = vq[i].e_addr ^ K;
            #1;
            check($sformatf("v%0d_req", i), {31'd0, ic_req}, {31'd0, vq[i].e_req});
            check($sformatf("v%0d_addr", i), ic_addr, vq[i].e_addr);
            check($sformatf("v%0d_block", i), {31'd0, block_pipe_instr_cache}, {31'd0, vq[i].e_blk});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), {31'd0, fetch_valid}, {31'd0, vq[i].e_valid});
            check($sformatf("v%0d_instr", i), instruction, vq[i].e_instr);
            check($sformatf("v%0d_pcnext", i), PCNEXT, vq[i].e_pcn);
        end

        // reset asserted between edges while a miss is outstanding
        @(negedge clk);
        en_fetch = 1'b1; redirect = 1'b0; ic_ready = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_req", {31'd0, ic_req}, 32'd0);
        check("arst_block", {31'd0, block_pipe_instr_cache}, 32'd0);
        check("arst_addr", ic_addr, RESET_PC);
        check("arst_instr", instruction, NOP);
        check("arst_pcnext", PCNEXT, 32'd0);
        check("arst_valid", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0; en_fetch = 1'b1; ic_ready = 1'b1; ic_data = K ^ RESET_PC;
        #1;
        check("arst_rel_req", {31'd0, ic_req}, 32'd1);
        check("arst_rel_addr", ic_addr, RESET_PC);
        @(posedge clk);
        #1;
        check("arst_rel_instr", instruction, K ^ RESET_PC);
        check("arst_rel_pcnext", PCNEXT, RESET_PC + 32'd4);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        e_req;
            logic [31:0] e_addr;
            @(negedge clk);
            en_fetch = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            ic_ready = ($urandom_range(0, 2) != 0);
            ic_data = $urandom;
            e_req  = model_req(en_fetch, redirect);
            e_addr = m_pc;
            #1;
            check($sformatf("r%0d_req", c), {31'd0, ic_req}, {31'd0, e_req});
            check($sformatf("r%0d_addr", c), ic_addr, e_addr);
            check($sformatf("r%0d_block", c), {31'd0, block_pipe_instr_cache}, {31'd0, e_req & ~ic_ready});
            model_step(en_fetch, redirect, redirect_pc, ic_ready, ic_data);
            @(posedge clk);
            #1;
            check($sformatf("r%0d_valid", c), {31'd0, fetch_valid}, {31'd0, m_valid});
            check($sformatf("r%0d_instr", c), instruction, m_instr);
            check($sformatf("r%0d_pcnext", c), PCNEXT, m_pcn);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
